// File: rtl/hdr_deparser_pkg.sv
// hdr_deparser_pkg: header ids, fixed header lengths and deparser state encodings
// Shared with the header parser, which uses the same HDR_LEN table.
package hdr_deparser_pkg;
   localparam int NUM_HEADERS   = 2;
   localparam int MAX_HDR_BYTES = 20;
   localparam int ADDR_W        = 32;
   localparam int ID_W          = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;
   localparam int IDX_W         = $clog2(MAX_HDR_BYTES);
   localparam int HDR_ETH       = 0;
   localparam int HDR_IPV4      = 1;
   localparam int NO_HEADER     = NUM_HEADERS;
   localparam int HDR_LEN [NUM_HEADERS] = '{14, 20};
   typedef enum logic [1:0] {
      STATE_IDLE,
      STATE_SELECT,
      STATE_WRITE,
      STATE_DONE
   } state_t;
   function automatic int first_hdr(input logic [NUM_HEADERS-1:0] v);
      first_hdr = NO_HEADER;
      for (int i = NUM_HEADERS - 1; i >= 0; i--)
         if (v[i]) first_hdr = i;
   endfunction
endpackage

// File: rtl/hdr_deparser_store.sv
// hdr_store: per-header byte RAM, one synchronous write port, one asynchronous read port
// Ports: clk; we/wr_id/wr_idx/wr_byte write port; rd_id/rd_idx -> rd_byte combinational read.
// Contents are deliberately not reset.
module hdr_store
   import hdr_deparser_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [ID_W-1:0]  wr_id,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_byte,
   input  logic [ID_W-1:0]  rd_id,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_byte
);
   logic [7:0] mem [NUM_HEADERS][MAX_HDR_BYTES];
   always_ff @(posedge clk)
      if (we && int'(wr_idx) < MAX_HDR_BYTES) mem[wr_id][wr_idx] <= wr_byte;
   assign rd_byte = mem[rd_id][rd_idx];
endmodule

// File: rtl/hdr_deparser.sv
// hdr_deparser: writes valid headers from the byte store back into packet SRAM, packed from a base address
// Ports: clk, rst (async, active-high); start_i/hdr_valid_i/base_addr_i start an emission;
// hdr_wr_* load the header store while idle; busy_o/done_o status; sram_* byte-write master
// (sram_data_i unused). Optional macro DEPARSER_LEN_OUT_EN adds out_len_o (bytes written).
module hdr_deparser
   import hdr_deparser_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [NUM_HEADERS-1:0] hdr_valid_i,
   input  logic [ADDR_W-1:0]      base_addr_i,
   input  logic                   hdr_wr_en_i,
   input  logic [ID_W-1:0]        hdr_wr_id_i,
   input  logic [IDX_W-1:0]       hdr_wr_idx_i,
   input  logic [7:0]             hdr_wr_byte_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   sram_ce_o,
   output logic                   sram_we_o,
   output logic [ADDR_W-1:0]      sram_addr_o,
   output logic [3:0]             sram_sel_o,
   output logic [31:0]            sram_data_o,
`ifdef DEPARSER_LEN_OUT_EN
   output logic [15:0]            out_len_o,
`endif
   input  logic [31:0]            sram_data_i
);
   state_t                 state, state_nxt;
   logic [NUM_HEADERS-1:0] vld_r;
   logic [ADDR_W-1:0]      cur_addr;
   logic [ID_W-1:0]        id_r;
   logic [IDX_W-1:0]       byte_cnt, last_idx;
   logic [7:0]             rd_byte;
   logic                   start_ok, wr_act, last_byte, found, unused_ok;
   int                     sel_id;
   assign unused_ok = ^sram_data_i;
   assign start_ok  = start_i && state == STATE_IDLE;
   assign sel_id    = first_hdr(vld_r);
   assign found     = sel_id != NO_HEADER;
   assign last_idx  = IDX_W'(HDR_LEN[id_r] - 1);
   assign last_byte = byte_cnt == last_idx;
   assign wr_act    = state == STATE_WRITE;
   always_comb begin
      state_nxt = state;
      case (state)
         STATE_IDLE:   state_nxt = start_i ? STATE_SELECT : STATE_IDLE;
         STATE_SELECT: state_nxt = found ? STATE_WRITE : STATE_DONE;
         STATE_WRITE:  state_nxt = last_byte ? STATE_SELECT : STATE_WRITE;
         default:      state_nxt = STATE_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= STATE_IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld_r    <= '0;
         cur_addr <= '0;
         id_r     <= '0;
         byte_cnt <= '0;
      end else begin
         if (start_ok) begin
            vld_r    <= hdr_valid_i;
            cur_addr <= base_addr_i;
            id_r     <= '0;
         end
         if (state == STATE_SELECT && found) begin
            vld_r    <= vld_r & ~(NUM_HEADERS'(1) << sel_id);
            id_r     <= ID_W'(sel_id);
            byte_cnt <= '0;
         end
         if (wr_act) begin
            cur_addr <= cur_addr + 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
         end
      end
   // Store writes are only accepted while idle, so an emission never sees its source change.
   hdr_store u_store (
      .clk     (clk),
      .we      (hdr_wr_en_i && state == STATE_IDLE),
      .wr_id   (hdr_wr_id_i),
      .wr_idx  (hdr_wr_idx_i),
      .wr_byte (hdr_wr_byte_i),
      .rd_id   (id_r),
      .rd_idx  (byte_cnt),
      .rd_byte (rd_byte)
   );
   assign busy_o      = state != STATE_IDLE;
   assign done_o      = state == STATE_DONE;
   assign sram_ce_o   = wr_act;
   assign sram_we_o   = wr_act;
   assign sram_addr_o = wr_act ? cur_addr : '0;
   assign sram_sel_o  = wr_act ? 4'b0001 << cur_addr[1:0] : 4'b0000;
   assign sram_data_o = wr_act ? {4{rd_byte}} : 32'h0;
`ifdef DEPARSER_LEN_OUT_EN
   logic [15:0] len_r;
   always_ff @(posedge clk or posedge rst)
      if (rst) len_r <= '0;
      else if (start_ok) len_r <= '0;
      else if (wr_act) len_r <= len_r + 1'b1;
   assign out_len_o = len_r;
`endif
endmodule

// File: tb/tb_hdr_deparser.sv
// tb_hdr_deparser: randomized self-checking bench for hdr_deparser against a byte-list reference model
module tb_hdr_deparser;
   import hdr_deparser_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  hdr_valid_i = '0;
   logic [31:0] base_addr_i = '0;
   logic        hdr_wr_en_i = 1'b0;
   logic [0:0]  hdr_wr_id_i = '0;
   logic [4:0]  hdr_wr_idx_i = '0;
   logic [7:0]  hdr_wr_byte_i = '0;
   logic        busy_o, done_o, sram_ce_o, sram_we_o;
   logic [31:0] sram_addr_o, sram_data_o;
   logic [3:0]  sram_sel_o;
`ifdef DEPARSER_LEN_OUT_EN
   logic [15:0] out_len_o;
`endif
   int checks = 0;
   int failures = 0;
   int tb_len [2] = '{14, 20};
   logic [7:0] mstore [2][20];
   always #5 clk = ~clk;
   hdr_deparser dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .hdr_valid_i   (hdr_valid_i),
      .base_addr_i   (base_addr_i),
      .hdr_wr_en_i   (hdr_wr_en_i),
      .hdr_wr_id_i   (hdr_wr_id_i),
      .hdr_wr_idx_i  (hdr_wr_idx_i),
      .hdr_wr_byte_i (hdr_wr_byte_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .sram_ce_o     (sram_ce_o),
      .sram_we_o     (sram_we_o),
      .sram_addr_o   (sram_addr_o),
      .sram_sel_o    (sram_sel_o),
      .sram_data_o   (sram_data_o),
`ifdef DEPARSER_LEN_OUT_EN
      .out_len_o     (out_len_o),
`endif
      .sram_data_i   (32'hDEAD_BEEF)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic load(input int id, input int idx, input logic [7:0] b);
      hdr_wr_en_i   = 1'b1;
      hdr_wr_id_i   = 1'(id);
      hdr_wr_idx_i  = 5'(idx);
      hdr_wr_byte_i = b;
      mstore[id][idx] = b;
      @(negedge clk);
      hdr_wr_en_i = 1'b0;
   endtask
   // inj: cycle at which to pulse start+store-write while busy (0 = none)
   // rst_after: assert reset after this many writes (0 = none); co_wr: store write together with start
   task automatic run(input logic [1:0] vld, input logic [31:0] base, input int inj,
                      input int rst_after, input bit co_wr);
      logic [31:0] ea [$];
      logic [7:0]  ed [$];
      logic [31:0] a = base;
      int n, w = 0, done_at = 0, ndone = 0, bad_busy = 0;
      start_i     = 1'b1;
      hdr_valid_i = vld;
      base_addr_i = base;
      if (co_wr) begin
         int id = $urandom_range(0, 1);
         int idx = $urandom_range(0, 19);
         logic [7:0] b = 8'($urandom);
         hdr_wr_en_i   = 1'b1;
         hdr_wr_id_i   = 1'(id);
         hdr_wr_idx_i  = 5'(idx);
         hdr_wr_byte_i = b;
         mstore[id][idx] = b;
      end
      for (int id = 0; id < 2; id++)
         if (vld[id])
            for (int b = 0; b < tb_len[id]; b++) begin
               ea.push_back(a);
               ed.push_back(mstore[id][b]);
               a = a + 1;
            end
      n = $countones(vld) + 1 + ea.size() + 1;
      @(negedge clk);
      hdr_valid_i = 2'($urandom);
      base_addr_i = $urandom;
      for (int cyc = 1; cyc <= n + 3; cyc++) begin
         start_i     = 1'b0;
         hdr_wr_en_i = 1'b0;
         if (busy_o !== (cyc <= n)) bad_busy++;
         if (done_o) begin
            ndone++;
            if (done_at == 0) done_at = cyc;
`ifdef DEPARSER_LEN_OUT_EN
            check("out_len", out_len_o, ea.size());
`endif
         end
         if (sram_ce_o) begin
            if (w < ea.size()) begin
               check("wr_addr", sram_addr_o, ea[w]);
               check("wr_data", sram_data_o, {4{ed[w]}});
               check("wr_sel", sram_sel_o, 4'b0001 << ea[w][1:0]);
               check("wr_we", sram_we_o, 1'b1);
            end
            w++;
         end
         if (rst_after > 0 && w == rst_after) begin
            #1 rst = 1'b1;
            #1;
            check("rst_ce", sram_ce_o, 1'b0);
            check("rst_we", sram_we_o, 1'b0);
            check("rst_busy", busy_o, 1'b0);
            @(negedge clk);
            check("rst_no_done", done_o, 1'b0);
            rst = 1'b0;
            @(negedge clk);
            check("rst_idle_done", done_o, 1'b0);
            return;
         end
         if (inj > 0 && cyc == inj) begin
            start_i       = 1'b1;
            hdr_valid_i   = 2'b11;
            base_addr_i   = 32'h0;
            hdr_wr_en_i   = 1'b1;
            hdr_wr_id_i   = 1'b1;
            hdr_wr_idx_i  = 5'd0;
            hdr_wr_byte_i = ~mstore[1][0];
         end
         @(negedge clk);
      end
      check("writes", w, ea.size());
      check("done_cycle", done_at, n);
      check("done_count", ndone, 1);
      check("busy_window", bad_busy, 0);
   endtask
   initial begin
      @(negedge clk);
      check("reset_ce", sram_ce_o, 1'b0);
      check("reset_we", sram_we_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_done", done_o, 1'b0);
      check("reset_addr", sram_addr_o, 32'h0);
      check("reset_sel", sram_sel_o, 4'h0);
      check("reset_data", sram_data_o, 32'h0);
`ifdef DEPARSER_LEN_OUT_EN
      check("reset_len", out_len_o, 16'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      for (int id = 0; id < 2; id++)
         for (int idx = 0; idx < 20; idx++)
            load(id, idx, 8'($urandom));
      run(2'b11, 32'h0000_0100, 0, 0, 1'b0);
      run(2'b10, 32'h0000_0003, 0, 0, 1'b0);
      run(2'b00, 32'h0000_0055, 0, 0, 1'b0);
      run(2'b11, 32'h0000_0200, 5, 0, 1'b0);
      run(2'b11, 32'h0000_0300, 20, 0, 1'b0);
      run(2'b01, 32'hFFFF_FFFE, 0, 0, 1'b0);
      run(2'b11, 32'h0000_0080, 0, 5, 1'b0);
      run(2'b11, 32'h0000_0040, 0, 0, 1'b0);
      run(2'b11, 32'h0000_0500, 0, 0, 1'b1);
      for (int k = 0; k < 20; k++)
         run(2'($urandom), $urandom, 0, 0, 1'($urandom_range(0, 1)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
